// File: rtl/cnnip_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnnip_pkg
// Description : Shared types and helpers for the CNN IP buffer arbiter slice.
// Revision    : 1.0 - initial release
// ============================================================================
package cnnip_pkg;

  // Arbiter ownership states
  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  // Rotating first-one search over up to 8 requesters. The search starts at
  // last+1 and wraps modulo n, so the previous winner has lowest priority.
  // If nothing is requesting, 'last' is returned unchanged.
  function automatic logic [2:0] rr_first(input logic [7:0] req,
                                          input logic [2:0] last,
                                          input logic [3:0] n);
    logic       found;
    logic [3:0] idx;
    found    = 1'b0;
    rr_first = last;
    for (int k = 1; k <= 8; k++) begin
      // last < n and k <= n, so one conditional subtract is a full modulo
      idx = {1'b0, last} + 4'(k);
      if (idx >= n) idx = idx - n;
      if (!found && (4'(k) <= n) && req[idx[2:0]]) begin
        found    = 1'b1;
        rr_first = idx[2:0];
      end
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/cnnip_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cnnip_fifo
// Description : Synchronous FIFO with registered full/empty flags and a
//               combinational read port at the head entry.
// Revision    : 1.0 - initial release
// ============================================================================
module cnnip_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic             clk_a,
  input  logic             arstz_aq,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  // Accesses are self-protecting so a careless caller cannot corrupt state
  assign do_push = push_i & ~full_q;
  assign do_pop  = pop_i  & ~empty_q;

  // Next pointers and the flags they imply; the extra MSB separates full from empty
  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    empty_d  = (wr_ptr_d == rd_ptr_d);
    full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
               (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
  end

  // Pointer and flag registers
  always_ff @(posedge clk_a or negedge arstz_aq) begin
    if (!arstz_aq) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage array; contents are don't-care while the FIFO is empty
  always_ff @(posedge clk_a) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule
`default_nettype wire

// File: rtl/cnnip_fifo_arb.sv
`default_nettype none
// ============================================================================
// Module      : cnnip_fifo_arb
// Description : Round-robin burst write arbiter in front of a shared FIFO.
//               Entries are tagged with the source index and drained through
//               a valid/ready master port; occupancy is exported.
// Revision    : 1.0 - initial release
// ============================================================================
module cnnip_fifo_arb
  import cnnip_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int WIDTH     = 32,
  parameter  int DEPTH     = 4,
  parameter  int BURST_LEN = 4,
  localparam int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int LVW       = $clog2(DEPTH + 1)
) (
  input  logic                     clk_a,
  input  logic                     arstz_aq,
  input  logic [NUM_REQ-1:0]       s_valid_a,
  input  logic [NUM_REQ*WIDTH-1:0] s_data_a,
  output logic [NUM_REQ-1:0]       s_ready_a,
  output logic                     m_valid_a,
  output logic [WIDTH-1:0]         m_data_a,
  output logic [IDW-1:0]           m_src_a,
  input  logic                     m_ready_a,
  output logic [NUM_REQ-1:0]       grant_a,
  output logic [LVW-1:0]           level_a
);

  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int EW = WIDTH + IDW;

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [IDW-1:0] rr_q, rr_d;
  logic [BW-1:0]  beat_q, beat_d;
  logic [LVW-1:0] level_q;

  logic [IDW-1:0] winner, sel;
  logic           push, pop;
  logic           full_a, empty_a;
  logic [EW-1:0]  din, dout;

  assign winner = IDW'(rr_first(8'(s_valid_a), 3'(rr_q), 4'(NUM_REQ)));

  // Grant/ready decode and next-state logic. The decode is masked while reset
  // is asserted so no requester sees a ready before the flops are released.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    beat_d    = beat_q;
    sel       = owner_q;
    push      = 1'b0;
    s_ready_a = '0;
    grant_a   = '0;
    if (arstz_aq) begin
      case (state_q)
        ARB_IDLE: begin
          if ((|s_valid_a) && !full_a) begin
            sel               = winner;
            push              = 1'b1;
            s_ready_a[winner] = 1'b1;
            grant_a[winner]   = 1'b1;
            owner_d           = winner;
            rr_d              = winner;
            // A single-beat grant never leaves IDLE, so every cycle re-arbitrates
            if (BURST_LEN > 1) begin
              state_d = ARB_BURST;
              beat_d  = BW'(1);
            end
          end
        end
        ARB_BURST: begin
          grant_a[owner_q]   = 1'b1;
          s_ready_a[owner_q] = ~full_a;
          if (!s_valid_a[owner_q]) begin
            // Owner dropped valid: give the buffer back without pushing
            state_d = ARB_IDLE;
            beat_d  = '0;
          end else if (!full_a) begin
            push = 1'b1;
            if (beat_q == BW'(BURST_LEN - 1)) begin
              state_d = ARB_IDLE;
              beat_d  = '0;
            end else begin
              beat_d = beat_q + 1'b1;
            end
          end
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

  // Arbiter state, owner, round-robin pointer and beat counter
  always_ff @(posedge clk_a or negedge arstz_aq) begin
    if (!arstz_aq) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
      rr_q    <= IDW'(NUM_REQ - 1);
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      beat_q  <= beat_d;
    end
  end

  assign din       = {sel, s_data_a[sel*WIDTH +: WIDTH]};
  assign m_valid_a = ~empty_a;
  assign pop       = m_valid_a & m_ready_a;
  assign {m_src_a, m_data_a} = dout;

  // Occupancy tracks the FIFO pointers edge for edge
  always_ff @(posedge clk_a or negedge arstz_aq) begin
    if (!arstz_aq) begin
      level_q <= '0;
    end else if (push && !pop) begin
      level_q <= level_q + 1'b1;
    end else if (!push && pop) begin
      level_q <= level_q - 1'b1;
    end
  end

  assign level_a = level_q;

  cnnip_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_a    (clk_a),
    .arstz_aq (arstz_aq),
    .push_i   (push),
    .pop_i    (pop),
    .din_i    (din),
    .dout_o   (dout),
    .full_o   (full_a),
    .empty_o  (empty_a)
  );

endmodule
`default_nettype wire

// File: tb/tb_cnnip_fifo_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_cnnip_fifo_arb
// Description : Directed self-checking bench for cnnip_fifo_arb. Instance u0
//               uses BURST_LEN=4, instance u1 uses BURST_LEN=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cnnip_fifo_arb;

  localparam int NR = 4;
  localparam int W  = 32;
  localparam int D  = 4;

  logic clk_a = 1'b0;
  logic arstz_aq;

  logic [NR-1:0]   v0, v1, rdy0, rdy1, g0, g1;
  logic [NR*W-1:0] d0, d1;
  logic            mv0, mv1, mr0, mr1;
  logic [W-1:0]    md0, md1;
  logic [1:0]      ms0, ms1;
  logic [2:0]      lv0, lv1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_a = ~clk_a;

  cnnip_fifo_arb #(.NUM_REQ(NR), .WIDTH(W), .DEPTH(D), .BURST_LEN(4)) u0 (
    .clk_a(clk_a), .arstz_aq(arstz_aq),
    .s_valid_a(v0), .s_data_a(d0), .s_ready_a(rdy0),
    .m_valid_a(mv0), .m_data_a(md0), .m_src_a(ms0), .m_ready_a(mr0),
    .grant_a(g0), .level_a(lv0)
  );

  cnnip_fifo_arb #(.NUM_REQ(NR), .WIDTH(W), .DEPTH(D), .BURST_LEN(1)) u1 (
    .clk_a(clk_a), .arstz_aq(arstz_aq),
    .s_valid_a(v1), .s_data_a(d1), .s_ready_a(rdy1),
    .m_valid_a(mv1), .m_data_a(md1), .m_src_a(ms1), .m_ready_a(mr1),
    .grant_a(g1), .level_a(lv1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample just after the edge
  task automatic tick();
    @(posedge clk_a);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    arstz_aq = 1'b0;
    v0 = 4'hF; v1 = 4'h0; mr0 = 1'b1; mr1 = 1'b1;
    for (int i = 0; i < NR; i++) begin
      d0[i*W +: W] = 32'hC0 + 32'(i);
      d1[i*W +: W] = 32'h10 + 32'(i);
    end
    tick(); tick();
    // ---- reset state with every requester valid
    chk("rst_ready", rdy0, 4'h0);
    chk("rst_grant", g0, 4'h0);
    chk("rst_mvalid", mv0, 1'b0);
    chk("rst_level", lv0, 3'd0);

    // ---- round robin from requester 0, 4-beat bursts
    arstz_aq = 1'b1; #1;
    chk("rr_first_grant", g0, 4'b0001);
    chk("rr_first_ready", rdy0, 4'b0001);
    tick();
    chk("rr_e1_level", lv0, 3'd1);
    chk("rr_e1_mvalid", mv0, 1'b1);
    chk("rr_e1_src", ms0, 2'd0);
    chk("rr_e1_data", md0, 32'hC0);
    tick(); tick();
    chk("rr_e3_grant", g0, 4'b0001);
    tick();
    chk("rr_e4_grant", g0, 4'b0010);
    chk("rr_e4_level", lv0, 3'd1);
    tick();
    chk("rr_e5_src", ms0, 2'd1);
    chk("rr_e5_data", md0, 32'hC1);
    tick(); tick(); tick();
    chk("rr_e8_grant", g0, 4'b0100);
    tick(); tick(); tick(); tick();
    chk("rr_e12_grant", g0, 4'b1000);
    tick(); tick(); tick(); tick();
    chk("rr_e16_grant", g0, 4'b0001);
    v0 = 4'h0; #1;
    chk("idle_grant", g0, 4'h0);
    chk("idle_ready", rdy0, 4'h0);
    tick();
    chk("drain_level", lv0, 3'd0);
    chk("drain_mvalid", mv0, 1'b0);

    // ---- requester 2 alone, early release after 2 beats
    mr0 = 1'b0; v0 = 4'b0100; d0[2*W +: W] = 32'hB0; #1;
    chk("r2_grant", g0, 4'b0100);
    tick();
    d0[2*W +: W] = 32'hB1;
    tick();
    chk("r2_level_peak", lv0, 3'd2);
    v0 = 4'h0;
    tick();
    chk("r2_release_level", lv0, 3'd2);
    chk("r2_release_grant", g0, 4'h0);
    chk("r2_out0_src", ms0, 2'd2);
    chk("r2_out0_data", md0, 32'hB0);
    mr0 = 1'b1;
    tick();
    chk("r2_pop_level", lv0, 3'd1);
    chk("r2_out1_src", ms0, 2'd2);
    chk("r2_out1_data", md0, 32'hB1);
    tick();
    chk("r2_empty", mv0, 1'b0);

    // ---- fill to full, pop frees space, then push+pop at level 2
    mr0 = 1'b0; v0 = 4'b0010; d0[1*W +: W] = 32'hA0; #1;
    chk("full_first_ready", rdy0, 4'b0010);
    tick(); d0[1*W +: W] = 32'hA1;
    tick(); d0[1*W +: W] = 32'hA2;
    tick(); d0[1*W +: W] = 32'hA3;
    tick(); d0[1*W +: W] = 32'hA4;
    chk("full_level", lv0, 3'd4);
    chk("full_ready", rdy0, 4'h0);
    chk("full_grant", g0, 4'h0);
    tick();
    chk("full_hold_ready", rdy0, 4'h0);
    chk("full_hold_level", lv0, 3'd4);
    chk("full_head", md0, 32'hA0);
    mr0 = 1'b1;
    tick();
    chk("pop_free_level", lv0, 3'd3);
    chk("pop_free_head", md0, 32'hA1);
    chk("pop_free_ready", rdy0, 4'b0010);
    tick();
    chk("fifth_level", lv0, 3'd3);
    chk("fifth_head", md0, 32'hA2);
    v0 = 4'h0;
    tick();
    chk("drop_level", lv0, 3'd2);
    chk("drop_head", md0, 32'hA3);
    v0 = 4'b0010; d0[1*W +: W] = 32'hA5;
    tick();
    chk("pp1_level", lv0, 3'd2);
    chk("pp1_head", md0, 32'hA4);
    d0[1*W +: W] = 32'hA6;
    tick();
    chk("pp2_level", lv0, 3'd2);
    chk("pp2_head", md0, 32'hA5);
    d0[1*W +: W] = 32'hA7;
    tick();
    chk("pp3_level", lv0, 3'd2);
    chk("pp3_head", md0, 32'hA6);
    v0 = 4'h0;
    tick();
    chk("tail_level", lv0, 3'd1);
    chk("tail_head", md0, 32'hA7);
    tick();
    chk("tail_empty", mv0, 1'b0);
    chk("tail_level0", lv0, 3'd0);

    // ---- reset mid-burst with 3 entries stored
    mr0 = 1'b0; v0 = 4'b0100; d0[2*W +: W] = 32'hE0;
    tick(); tick(); tick();
    chk("mid_level", lv0, 3'd3);
    chk("mid_grant", g0, 4'b0100);
    arstz_aq = 1'b0; #1;
    chk("arst_mvalid", mv0, 1'b0);
    chk("arst_level", lv0, 3'd0);
    chk("arst_grant", g0, 4'h0);
    chk("arst_ready", rdy0, 4'h0);
    tick();
    v0 = 4'hF; v1 = 4'b1010; arstz_aq = 1'b1; #1;
    chk("post_rst_grant", g0, 4'b0001);

    // ---- single-beat grants alternate between requesters 1 and 3
    chk("bl1_g0", g1, 4'b0010);
    v0 = 4'h0;
    tick();
    chk("bl1_src0", ms1, 2'd1);
    chk("bl1_data0", md1, 32'h11);
    chk("bl1_g1", g1, 4'b1000);
    tick();
    chk("bl1_src1", ms1, 2'd3);
    chk("bl1_data1", md1, 32'h13);
    chk("bl1_g2", g1, 4'b0010);
    tick();
    chk("bl1_src2", ms1, 2'd1);
    chk("bl1_g3", g1, 4'b1000);
    chk("bl1_level", lv1, 3'd1);

    v1 = 4'h0;
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
